// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO write-port scheduler.
// Holds the arbiter state enum, default FIFO sizing and pointer rotation.
package fifo_sched_pkg;

  typedef enum logic {
    ARB,
    LOCK
  } state_t;

  localparam int AB    = 5;
  localparam int DEPTH = 2 ** AB;
  localparam int CW    = AB + 1;
  localparam int PW    = 3;

  function automatic logic [PW-1:0] rr_next(
    input logic [PW-1:0] ptr,
    input int            n
  );
    if (int'(ptr) >= n - 1) return '0;
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr.
// Produces a one-hot grant plus its binary index.
module fifo_rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [N-1:0] hi;
  logic [N-1:0] src;

  always_comb begin
    hi = req;
    for (int i = 0; i < N; i++) begin
      if (i < int'(ptr)) hi[i] = 1'b0;
    end
    // no request at/after ptr: wrap to lowest index
    src = (|hi) ? hi : req;
    gnt = src & (~src + 1'b1);
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = PW'(i);
    end
  end

endmodule

// File: rtl/fifo_wr_scheduler.sv
// Round-robin / burst-lock sharing of one FIFO write port with credit flow control.
// Define FIFO_SCHED_STATS_EN to add per-requester 16-bit beat counters on port stat.
module fifo_wr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int rw    = 8,
  parameter int ab    = AB,
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic                c,
  input  logic                re,
  input  logic [N-1:0]        req,
  input  logic [N*rw-1:0]     din,
  output logic [N-1:0]        ack,
  output logic                ws,
  output logic [rw-1:0]       wd,
  input  logic                rs_obs,
  input  logic                es,
  input  logic                fs,
  input  logic                of,
  output logic [ab:0]         credit,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gid,
  output logic                err
`ifdef FIFO_SCHED_STATS_EN
  ,
  output logic [N*16-1:0]     stat
`endif
);

  localparam int DEP = (ab == AB) ? DEPTH : 2 ** ab;
  localparam int CWD = (ab == AB) ? CW : ab + 1;
  localparam int GW  = (N > 1) ? $clog2(N) : 1;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic [CWD-1:0] bcnt;

  logic [PW-1:0]  gid_ext;
  logic [PW-1:0]  eff_ptr;
  logic [N-1:0]   pick_gnt;
  logic [PW-1:0]  pick_idx;
  logic [PW-1:0]  sel;
  logic [rw-1:0]  din_sel;
  logic           open;
  logic           lock_hold;
  logic           hold_ok;
  logic           xfer;
  logic           inc;

  fifo_rr_pick #(
    .N(N)
  ) u_pick (
    .req(req),
    .ptr(eff_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

  always_comb begin
    gid_ext   = PW'(gid);
    open      = (credit != '0) & ~fs & re;
    lock_hold = (state == LOCK) & req[gid]
              & (bcnt < CWD'(BURST));
    hold_ok   = lock_hold & open;
    // a lapsing lock re-arbitrates from gid+1 in the same cycle
    eff_ptr   = (state == LOCK) ? rr_next(gid_ext, N) : ptr;
    ack       = '0;
    sel       = pick_idx;
    if (open) begin
      if (lock_hold) begin
        ack[gid] = 1'b1;
        sel      = gid_ext;
      end else begin
        ack = pick_gnt;
      end
    end
    xfer    = |(req & ack);
    inc     = rs_obs & ~es;
    din_sel = din[int'(sel)*rw +: rw];
  end

  always_ff @(posedge c or negedge re) begin
    if (!re) begin
      state  <= ARB;
      ptr    <= '0;
      bcnt   <= '0;
      gid    <= '0;
      ws     <= 1'b0;
      wd     <= '0;
      credit <= CWD'(DEP);
      err    <= 1'b0;
    end else begin
      ws <= xfer;
      if (xfer) begin
        wd <= din_sel;
        if (hold_ok) begin
          bcnt <= bcnt + 1'b1;
        end else begin
          gid   <= GW'(sel);
          bcnt  <= CWD'(1);
          state <= (BURST > 1) ? LOCK : ARB;
          ptr   <= rr_next(sel, N);
        end
      end else if (state == LOCK) begin
        state <= ARB;
        ptr   <= rr_next(gid_ext, N);
      end

      unique case (1'b1)
        (inc & ~xfer): begin
          if (credit == CWD'(DEP)) err <= 1'b1;
          else credit <= credit + 1'b1;
        end
        (xfer & ~inc): begin
          if (credit == '0) err <= 1'b1;
          else credit <= credit - 1'b1;
        end
        default: ;
      endcase

      if (of) err <= 1'b1;
      // full flag while credit says space: counter has drifted
      if (fs && (credit != '0)) err <= 1'b1;
    end
  end

`ifdef FIFO_SCHED_STATS_EN
  always_ff @(posedge c or negedge re) begin
    if (!re) begin
      stat <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (xfer && ack[i])
          stat[i*16 +: 16] <= stat[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
